// File: rtl/rotate_shift_unit_seq_pkg.sv
// Shared encodings for the multi-cycle rotate/shift unit (also used by the ALU decoder).
package rotate_shift_unit_seq_pkg;

    typedef enum logic [2:0] {
        RSU_ROL  = 3'b000,
        RSU_ROR  = 3'b001,
        RSU_RCL  = 3'b010,
        RSU_RCR  = 3'b011,
        RSU_SHL  = 3'b100,
        RSU_SHR  = 3'b101,
        RSU_SAR  = 3'b110,
        RSU_RSVD = 3'b111
    } rsu_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rsu_state_e;

endpackage

// File: rtl/rotate_shift_unit_seq_step.sv
// Combinational single-position step: (mode, w, c) -> (w', c').
module rotate_shift_unit_seq_step
    import rotate_shift_unit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  rsu_mode_e        mode,
    input  logic [WIDTH-1:0] w,
    input  logic             c,
    output logic [WIDTH-1:0] w_nxt_c,
    output logic             c_nxt_c
);

    localparam int unsigned M = WIDTH - 1;

    // One bit of rotate/shift; reserved mode holds the working value.
    always_comb begin
        w_nxt_c = w;
        c_nxt_c = c;
        case (mode)
            RSU_ROL: begin
                c_nxt_c = w[M];
                w_nxt_c = {w[M-1:0], w[M]};
            end
            RSU_ROR: begin
                c_nxt_c = w[0];
                w_nxt_c = {w[0], w[M:1]};
            end
            RSU_RCL: begin
                c_nxt_c = w[M];
                w_nxt_c = {w[M-1:0], c};
            end
            RSU_RCR: begin
                c_nxt_c = w[0];
                w_nxt_c = {c, w[M:1]};
            end
            RSU_SHL: begin
                c_nxt_c = w[M];
                w_nxt_c = {w[M-1:0], 1'b0};
            end
            RSU_SHR: begin
                c_nxt_c = w[0];
                w_nxt_c = {1'b0, w[M:1]};
            end
            RSU_SAR: begin
                c_nxt_c = w[0];
                w_nxt_c = {w[M], w[M:1]};
            end
            default: begin
                w_nxt_c = w;
                c_nxt_c = c;
            end
        endcase
    end

endmodule

// File: rtl/rotate_shift_unit_seq.sv
// Multi-cycle rotate/shift unit: one bit position per clock, start/busy/done handshake,
// result and CF/SF/ZF held until the next accepted operation.
module rotate_shift_unit_seq
    import rotate_shift_unit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned AMT_W = WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] b,
    input  logic             cf_in,
    output logic [WIDTH-1:0] r,
    output logic             cf,
    output logic             sf,
    output logic             zf,
    output logic             busy,
    output logic             done
);

    // Reduction is done at the wider of the amount and counter widths so that
    // neither the full b value nor WIDTH+1 is truncated before mod/min.
    localparam int unsigned RED_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;

    rsu_state_e       state;
    rsu_mode_e        mode_q;
    logic [WIDTH-1:0] work;
    logic             c_q;
    logic [CNT_W-1:0] cnt;

    logic [RED_W-1:0] b_ext_c;
    logic [RED_W-1:0] b_mod_rot_c;
    logic [RED_W-1:0] b_mod_rc_c;
    logic [RED_W-1:0] b_min_c;
    logic [CNT_W-1:0] ceff_c;

    logic [WIDTH-1:0] step_w_c;
    logic             step_c_c;

    // Effective step count for the operation being offered on the inputs.
    always_comb begin
        b_ext_c     = RED_W'(b);
        b_mod_rot_c = b_ext_c % RED_W'(WIDTH);
        b_mod_rc_c  = b_ext_c % RED_W'(WIDTH + 1);
        b_min_c     = (b_ext_c > RED_W'(WIDTH)) ? RED_W'(WIDTH) : b_ext_c;
        ceff_c      = '0;
        case (rsu_mode_e'(mode))
            RSU_ROL, RSU_ROR:          ceff_c = CNT_W'(b_mod_rot_c);
            RSU_RCL, RSU_RCR:          ceff_c = CNT_W'(b_mod_rc_c);
            RSU_SHL, RSU_SHR, RSU_SAR: ceff_c = CNT_W'(b_min_c);
            default:                   ceff_c = '0;
        endcase
    end

    rotate_shift_unit_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode    (mode_q),
        .w       (work),
        .c       (c_q),
        .w_nxt_c (step_w_c),
        .c_nxt_c (step_c_c)
    );

    // Control FSM, iteration registers and held result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= RSU_ROL;
            work   <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            r      <= '0;
            cf     <= 1'b0;
            sf     <= 1'b0;
            zf     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        mode_q <= rsu_mode_e'(mode);
                        work   <= a;
                        c_q    <= cf_in;
                        cnt    <= ceff_c;
                        busy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt != '0) begin
                        work <= step_w_c;
                        c_q  <= step_c_c;
                        cnt  <= cnt - CNT_W'(1);
                    end else begin
                        r     <= work;
                        cf    <= c_q;
                        sf    <= work[WIDTH-1];
                        zf    <= (work == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
